seg7_display_ctrl: RTL and testbench

Register-mapped output peripheral. It drives a 4-digit multiplexed common-anode 7-segment display, for example the score or speed readout of the game. The CPU writes hex digits and control bits over the same 4-bit-address register bus used by the button peripheral. The block time-multiplexes the digits, supports blanking, decimal points and blink, and raises an interrupt at every frame boundary.

---
 rtl/seg7_display_ctrl_if.sv | 23 ++
 rtl/seg7_display_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_seg7_display_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_display_ctrl_if.sv
// Register bus bundle for seg7_display_ctrl.
// master = CPU side (drives writes/read address), slave = peripheral (drives rd_data).
interface seg7_display_ctrl_if;
  logic [3:0]  wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [3:0]  rd_addr;
  logic        rd_en;
  logic [31:0] rd_data;

  modport master (
    output wr_addr, wr_en, wr_data, wr_strb,
    output rd_addr, rd_en,
    input  rd_data
  );

  modport slave (
    input  wr_addr, wr_en, wr_data, wr_strb,
    input  rd_addr, rd_en,
    output rd_data
  );
endinterface

// File: rtl/seg7_display_ctrl.sv
// 4-digit multiplexed common-anode 7-segment controller with blink and frame irq.
// Ports: clk, rst (sync, active-high), bus (register slave), seg_n, dig_n, irq.
module seg7_display_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_display_ctrl_if.slave   bus,
  output logic [7:0]           seg_n,
  output logic [3:0]           dig_n,
  output logic                 irq
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ?
                      $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_CTRL = 2'd1;
  localparam logic [1:0] A_IER  = 2'd2;
  localparam logic [1:0] A_IFR  = 2'd3;

  logic [15:0]   r_data;
  logic [8:0]    r_ctrl;
  logic          r_ier;
  logic          r_ifr;
  logic [15:0]   r_sh_data;
  logic [8:0]    r_sh_ctrl;
  logic          r_blink_phase;
  logic [BW-1:0] r_blink_cnt;
  logic [1:0]    r_dig_idx;
  logic [CW-1:0] r_scan_cnt;
  logic [7:0]    r_seg_n;
  logic [3:0]    r_dig_n;

  logic       w_tc;
  logic       w_frame;
  logic       w_full;
  logic       w_wr_data;
  logic       w_wr_ctrl;
  logic       w_wr_ier;
  logic       w_wr_ifr;
  logic [3:0] w_en_vec;
  logic [3:0] w_dp_vec;
  logic [3:0] w_nib;
  logic       w_on;
  logic       w_unused;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_tc    = (r_scan_cnt == '0);
  assign w_frame = w_tc & (r_dig_idx == 2'd3);
  assign w_full  = (bus.wr_strb == 4'hF);

  assign w_wr_data = bus.wr_en & (bus.wr_addr[3:2] == A_DATA);
  assign w_wr_ctrl = bus.wr_en & (bus.wr_addr[3:2] == A_CTRL) & w_full;
  assign w_wr_ier  = bus.wr_en & (bus.wr_addr[3:2] == A_IER)  & w_full;
  assign w_wr_ifr  = bus.wr_en & (bus.wr_addr[3:2] == A_IFR)  & w_full;

  assign w_unused = ^{bus.wr_addr[1:0], bus.rd_addr[1:0],
                      bus.wr_data[31:16]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= SCAN_LAST;
      r_dig_idx  <= 2'd0;
    end else if (w_tc) begin
      r_scan_cnt <= SCAN_LAST;
      r_dig_idx  <= r_dig_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt - CW'(1);
    end
  end

  // Shadow copy is what the display shows; it only moves at frame
  // boundaries so a multi-write update never appears half-applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_data     <= '0;
      r_sh_ctrl     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame) begin
      r_sh_data <= r_data;
      r_sh_ctrl <= r_ctrl;
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_ctrl <= '0;
      r_ier  <= 1'b0;
    end else begin
      if (w_wr_data && bus.wr_strb[0])
        r_data[7:0] <= bus.wr_data[7:0];
      if (w_wr_data && bus.wr_strb[1])
        r_data[15:8] <= bus.wr_data[15:8];
      if (w_wr_ctrl)
        r_ctrl <= bus.wr_data[8:0];
      if (w_wr_ier)
        r_ier <= bus.wr_data[0];
    end
  end

  // Frame set has priority over a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (rst)
      r_ifr <= 1'b0;
    else if (w_frame)
      r_ifr <= 1'b1;
    else if (w_wr_ifr && bus.wr_data[0])
      r_ifr <= 1'b0;
  end

  assign w_en_vec = r_sh_ctrl[3:0];
  assign w_dp_vec = r_sh_ctrl[7:4];
  assign w_nib    = r_sh_data[{r_dig_idx, 2'b00} +: 4];
  assign w_on     = w_en_vec[r_dig_idx] &
                    ~(r_sh_ctrl[8] & r_blink_phase);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_n <= 8'hFF;
      r_dig_n <= 4'hF;
    end else if (w_on) begin
      r_seg_n <= ~{w_dp_vec[r_dig_idx], hex7(w_nib)};
      r_dig_n <= ~(4'b0001 << r_dig_idx);
    end else begin
      r_seg_n <= 8'hFF;
      r_dig_n <= 4'hF;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    if (bus.rd_en) begin
      unique case (bus.rd_addr[3:2])
        A_DATA: bus.rd_data = {16'd0, r_data};
        A_CTRL: bus.rd_data = {23'd0, r_ctrl};
        A_IER:  bus.rd_data = {31'd0, r_ier};
        A_IFR:  bus.rd_data = {31'd0, r_ifr};
      endcase
    end
  end

  assign seg_n = r_seg_n;
  assign dig_n = r_dig_n;
  assign irq   = r_ier & r_ifr;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed scoreboard bench for seg7_display_ctrl (SCAN_DIV=4, BLINK_FRAMES=2).
// n counts clock edges since reset release; frame m is shown on edges 16m+1..16m+16.
module tb_seg7_display_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seg_n;
  logic [3:0] dig_n;
  logic       irq;

  int checks = 0;
  int errors = 0;
  int n = 0;

  localparam logic [3:0] A_DATA = 4'h0;
  localparam logic [3:0] A_CTRL = 4'h4;
  localparam logic [3:0] A_IER  = 4'h8;
  localparam logic [3:0] A_IFR  = 4'hC;

  seg7_display_ctrl_if bus();

  seg7_display_ctrl #(
    .SCAN_DIV(4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .seg_n(seg_n),
    .dig_n(dig_n),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] dig;
    logic [7:0] seg;
  } exp_t;

  exp_t q[$];

  logic [6:0] hex_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  task automatic step();
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%h expected=%h",
             tag, n, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag,
                        input logic [3:0] a,
                        input logic [31:0] e);
    bus.rd_addr = a;
    bus.rd_en   = 1'b1;
    #1;
    chk(tag, bus.rd_data, e);
    bus.rd_en   = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s);
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_strb = s;
    bus.wr_en   = 1'b1;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] d,
                            input logic [8:0] c,
                            input bit ph);
    exp_t e;
    bit   on;
    logic [3:0] nib;
    for (int k = 0; k < 4; k++) begin
      on  = c[k] && !(c[8] && ph);
      nib = d[4*k +: 4];
      if (on) begin
        e.dig = ~(4'b0001 << k);
        e.seg = ~{c[4+k], hex_tbl[nib]};
      end else begin
        e.dig = 4'hF;
        e.seg = 8'hFF;
      end
      q.push_back(e);
    end
  endtask

  task automatic check_frame(input string tag, input int m);
    exp_t e;
    int   t;
    for (int k = 0; k < 4; k++) begin
      t = 16*m + 4*k + 2;
      while (n < t) step();
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s scoreboard empty at n=%0d", tag, n);
      end else begin
        e = q.pop_front();
        chk({tag, "_dig"}, 32'(dig_n), 32'(e.dig));
        chk({tag, "_seg"}, 32'(seg_n), 32'(e.seg));
      end
    end
    while (n < 16*m + 16) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_strb = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n   = 0;

    // reset state
    chk("rst_seg", 32'(seg_n), 32'hFF);
    chk("rst_dig", 32'(dig_n), 32'hF);
    chk("rst_irq", 32'(irq), 32'h0);
    rd_chk("rst_data", A_DATA, 32'h0);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_ier",  A_IER,  32'h0);
    rd_chk("rst_ifr",  A_IFR,  32'h0);

    // basic display
    wr(A_DATA, 32'h0000_12AF, 4'hF);
    wr(A_CTRL, 32'h0000_000F, 4'hF);
    rd_chk("rd_data", A_DATA, 32'h12AF);
    rd_chk("rd_ctrl", A_CTRL, 32'h000F);
    bus.rd_addr = A_DATA;
    #1;
    chk("rd_en_low", bus.rd_data, 32'h0);
    chk("pre_frame_dig", 32'(dig_n), 32'hF);
    while (n < 15) step();
    rd_chk("ifr_before_tc", A_IFR, 32'h0);
    step();
    rd_chk("ifr_at_frame", A_IFR, 32'h1);
    chk("irq_masked", 32'(irq), 32'h0);
    push_frame(16'h12AF, 9'h00F, 1'b0);
    check_frame("basic_f1", 1);
    push_frame(16'h12AF, 9'h00F, 1'b0);
    check_frame("basic_f2", 2);

    // byte strobes and decimal points
    wr(A_DATA, 32'h0000_FFFF, 4'b0001);
    rd_chk("strb_lo", A_DATA, 32'h12FF);
    wr(A_CTRL, 32'h0000_0025, 4'hF);
    push_frame(16'h12FF, 9'h025, 1'b0);
    check_frame("ctrl25", 4);
    wr(A_CTRL, 32'h0000_0045, 4'hF);
    rd_chk("rd_ctrl45", A_CTRL, 32'h45);
    push_frame(16'h12FF, 9'h045, 1'b0);
    check_frame("dp2", 6);

    // anti-tearing: write lands on the boundary edge 128
    while (n < 127) step();
    wr(A_DATA, 32'h0000_3333, 4'hF);
    push_frame(16'h12FF, 9'h045, 1'b0);
    check_frame("tear_old", 8);
    push_frame(16'h3333, 9'h045, 1'b0);
    check_frame("tear_new", 9);

    // interrupt
    wr(A_IFR, 32'h1, 4'hF);
    rd_chk("ifr_w1c", A_IFR, 32'h0);
    wr(A_IER, 32'h1, 4'hF);
    rd_chk("rd_ier", A_IER, 32'h1);
    chk("irq_idle", 32'(irq), 32'h0);
    while (n < 175) step();
    chk("irq_pre_frame", 32'(irq), 32'h0);
    step();
    chk("irq_rise", 32'(irq), 32'h1);
    while (n < 191) step();
    wr(A_IFR, 32'h1, 4'hF);
    rd_chk("ifr_set_wins", A_IFR, 32'h1);
    chk("irq_set_wins", 32'(irq), 32'h1);
    wr(A_IFR, 32'h1, 4'b0011);
    chk("ifr_partial", 32'(irq), 32'h1);
    wr(A_IFR, 32'h0, 4'hF);
    chk("ifr_w1c_zero", 32'(irq), 32'h1);
    wr(A_IFR, 32'h1, 4'hF);
    chk("irq_cleared", 32'(irq), 32'h0);
    rd_chk("ifr_cleared", A_IFR, 32'h0);
    while (n < 207) step();
    chk("irq_hold_low", 32'(irq), 32'h0);
    step();
    chk("irq_rise2", 32'(irq), 32'h1);

    // ignored writes
    wr(A_CTRL, 32'h0, 4'b0111);
    rd_chk("ctrl_partial", A_CTRL, 32'h45);
    wr(A_DATA, 32'hABCD_ABCD, 4'b1100);
    rd_chk("data_hi_strb", A_DATA, 32'h3333);
    wr(A_IER, 32'h0, 4'b0001);
    rd_chk("ier_partial", A_IER, 32'h1);

    // blink: phase keeps running from reset, frame 14/15 blank, 16/17 lit
    wr(A_CTRL, 32'h0000_010F, 4'hF);
    push_frame(16'h3333, 9'h10F, 1'b1);
    check_frame("blink_f14", 14);
    push_frame(16'h3333, 9'h10F, 1'b1);
    check_frame("blink_f15", 15);
    push_frame(16'h3333, 9'h10F, 1'b0);
    check_frame("blink_f16", 16);
    push_frame(16'h3333, 9'h10F, 1'b0);
    check_frame("blink_f17", 17);
    // BLINK cleared early in a blank frame: stays blank until next load
    push_frame(16'h3333, 9'h10F, 1'b1);
    wr(A_CTRL, 32'h0000_000F, 4'hF);
    check_frame("unblink_f18", 18);
    push_frame(16'h3333, 9'h00F, 1'b1);
    check_frame("unblink_f19", 19);

    // reset mid-frame
    while (n < 326) step();
    rst = 1'b1;
    step();
    chk("mid_rst_seg", 32'(seg_n), 32'hFF);
    chk("mid_rst_dig", 32'(dig_n), 32'hF);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    rd_chk("mid_rst_data", A_DATA, 32'h0);
    rd_chk("mid_rst_ctrl", A_CTRL, 32'h0);
    rd_chk("mid_rst_ier",  A_IER,  32'h0);
    rd_chk("mid_rst_ifr",  A_IFR,  32'h0);
    rst = 1'b0;
    n   = 0;

    wr(A_DATA, 32'h0000_12AF, 4'hF);
    wr(A_CTRL, 32'h0000_010F, 4'hF);
    wr(A_IER,  32'h1, 4'hF);
    chk("post_rst_blank", 32'(dig_n), 32'hF);
    while (n < 15) step();
    chk("post_rst_irq_lo", 32'(irq), 32'h0);
    step();
    chk("post_rst_irq_hi", 32'(irq), 32'h1);
    push_frame(16'h12AF, 9'h10F, 1'b0);
    check_frame("rblink_f1", 1);
    push_frame(16'h12AF, 9'h10F, 1'b1);
    check_frame("rblink_f2", 2);
    push_frame(16'h12AF, 9'h10F, 1'b1);
    check_frame("rblink_f3", 3);
    push_frame(16'h12AF, 9'h10F, 1'b0);
    check_frame("rblink_f4", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
